ren_tile_fetch: RTL

Read-side consumer of the binner's raster tile FIFO. Pops one `tile_t` at a time, once the binner has written it and the FIFO is non-empty. Walks the tile as a raster of BLK×BLK pixel blocks and presents each block origin to the rasterizer over a valid/ready handshake. Trivially-accepted (fully covered) tiles are forwarded as a single beat so the rasterizer can flood-fill them.

---
 rtl/ren_pkg.sv | 21 ++
 rtl/ren_tile_fetch_pkg.sv | 21 ++
 rtl/ren_tile_fetch_if.sv | 32 +++
 rtl/ren_tile_fetch.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/ren_pkg.sv
// Shared rasterizer package.
// Holds the fixed-point and edge types used across the render pipeline and
// the tile record that the binner writes into the raster tile FIFO.
package ren_pkg;

  typedef logic signed [21:0] fp22_t;

  typedef struct packed {
    fp22_t a;
    fp22_t b;
    fp22_t c;
  } edge_t;

  // One binned tile: tile indices in tile units, plus the trivial-accept flag.
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        full;
  } tile_t;

endpackage

// File: rtl/ren_tile_fetch_pkg.sv
// Package for the tile fetcher.
// Provides the fetcher state enum and the derivation of LOG2_N, the number
// of bits needed to index a block within one tile row or column.
package ren_tile_fetch_pkg;

  typedef enum logic [1:0] {
    TF_IDLE,
    TF_WAIT,
    TF_EMIT
  } tf_state_e;

  localparam int TF_TILE_SIZE = 16;
  localparam int TF_BLK       = 4;

  function automatic int tf_log2_n(input int tile_size, input int blk);
    return $clog2(tile_size / blk);
  endfunction

  localparam int LOG2_N = tf_log2_n(TF_TILE_SIZE, TF_BLK);

endpackage

// File: rtl/ren_tile_fetch_if.sv
// Bundle between the tile fetcher, the external tile FIFO and the rasterizer.
//   i_en, i_fifo_empty, i_tile, o_fifo_read : tile FIFO read side
//   o_valid, i_ready, o_px, o_py, o_full,
//   o_last, o_busy                          : block beats toward the rasterizer
// master = the fetcher, slave = the FIFO/rasterizer environment.
interface ren_tile_fetch_if #(
  parameter int PIX_W = 16
) ();

  logic               i_en;
  logic               i_fifo_empty;
  ren_pkg::tile_t     i_tile;
  logic               o_fifo_read;
  logic               o_valid;
  logic               i_ready;
  logic [PIX_W-1:0]   o_px;
  logic [PIX_W-1:0]   o_py;
  logic               o_full;
  logic               o_last;
  logic               o_busy;

  modport master (
    input  i_en, i_fifo_empty, i_tile, i_ready,
    output o_fifo_read, o_valid, o_px, o_py, o_full, o_last, o_busy
  );

  modport slave (
    output i_en, i_fifo_empty, i_tile, i_ready,
    input  o_fifo_read, o_valid, o_px, o_py, o_full, o_last, o_busy
  );

endinterface

// File: rtl/ren_tile_fetch.sv
// Tile fetcher: pops tiles from the binner's raster tile FIFO and walks each
// one as a raster of BLK x BLK blocks, handing block origins to the
// rasterizer over valid/ready. Trivially-accepted tiles go out as one beat.
// Ports:
//   clk  : clock, rising edge
//   rstn : synchronous reset, active high
//   bus  : ren_tile_fetch_if master (FIFO pop side + block beat side)
module ren_tile_fetch
  import ren_pkg::*;
  import ren_tile_fetch_pkg::*;
#(
  parameter int TILE_SIZE = 16,
  parameter int BLK       = 4,
  parameter int PIX_W     = 16
) (
  input  logic              clk,
  input  logic              rstn,
  ren_tile_fetch_if.master  bus
);

  localparam int N_BLK      = TILE_SIZE / BLK;
  localparam int BLK_LOG2_N = tf_log2_n(TILE_SIZE, BLK);
  localparam int CNT_W      = (BLK_LOG2_N > 0) ? BLK_LOG2_N : 1;
  localparam int TS_SH      = $clog2(TILE_SIZE);
  localparam int BLK_SH     = $clog2(BLK);
  localparam logic [CNT_W-1:0] MAX_IDX = CNT_W'(N_BLK - 1);

  tf_state_e         state_q, state_d;
  logic [15:0]       tx_q, tx_d, ty_q, ty_d;
  logic [CNT_W-1:0]  bx_q, bx_d, by_q, by_d;
  logic [CNT_W-1:0]  bx_n, by_n;
  logic              full_q, full_d, last_q, last_d;
  logic              valid_q, valid_d, busy_q, busy_d;
  logic [PIX_W-1:0]  px_q, px_d, py_q, py_d;
  logic              fifo_read, can_pop, handshake;

  // Tile index times tile size plus block index times block size, with the
  // multiplications done as shifts and the sum wrapping at PIX_W bits.
  function automatic logic [PIX_W-1:0] origin(input logic [15:0] t,
                                              input logic [CNT_W-1:0] b);
    logic [PIX_W-1:0] tw;
    logic [PIX_W-1:0] bw;
    tw = PIX_W'(t);
    bw = PIX_W'(b);
    return (tw << TS_SH) + (bw << BLK_SH);
  endfunction

  // Next-state logic. The pop strobe is decided combinationally so that a
  // tile can be popped in the same cycle as the last beat's handshake,
  // leaving exactly one WAIT bubble between back-to-back tiles. All beat
  // outputs are computed one cycle ahead so they come straight from flops.
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    ty_d      = ty_q;
    bx_d      = bx_q;
    by_d      = by_q;
    full_d    = full_q;
    last_d    = last_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    px_d      = px_q;
    py_d      = py_q;
    fifo_read = 1'b0;
    can_pop   = bus.i_en && !bus.i_fifo_empty;
    handshake = valid_q && bus.i_ready;
    bx_n      = (bx_q == MAX_IDX) ? '0 : bx_q + 1'b1;
    by_n      = (bx_q == MAX_IDX) ? by_q + 1'b1 : by_q;

    case (state_q)
      TF_IDLE: begin
        if (can_pop) begin
          fifo_read = 1'b1;
          state_d   = TF_WAIT;
          busy_d    = 1'b1;
        end
      end
      TF_WAIT: begin
        tx_d    = bus.i_tile.x;
        ty_d    = bus.i_tile.y;
        full_d  = bus.i_tile.full;
        bx_d    = '0;
        by_d    = '0;
        px_d    = origin(bus.i_tile.x, '0);
        py_d    = origin(bus.i_tile.y, '0);
        last_d  = bus.i_tile.full || (BLK_LOG2_N == 0);
        valid_d = 1'b1;
        busy_d  = 1'b1;
        state_d = TF_EMIT;
      end
      TF_EMIT: begin
        if (handshake) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            full_d  = 1'b0;
            if (can_pop) begin
              fifo_read = 1'b1;
              state_d   = TF_WAIT;
              busy_d    = 1'b1;
            end else begin
              state_d   = TF_IDLE;
              busy_d    = 1'b0;
            end
          end else begin
            bx_d   = bx_n;
            by_d   = by_n;
            px_d   = origin(tx_q, bx_n);
            py_d   = origin(ty_q, by_n);
            last_d = (bx_n == MAX_IDX) && (by_n == MAX_IDX);
          end
        end
      end
      default: state_d = TF_IDLE;
    endcase
  end

  // State and output registers; reset drops any held tile.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q <= TF_IDLE;
      tx_q    <= '0;
      ty_q    <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      full_q  <= 1'b0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      px_q    <= '0;
      py_q    <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      full_q  <= full_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      px_q    <= px_d;
      py_q    <= py_d;
    end
  end

  // Reset overrides a pop request raised in the same cycle.
  assign bus.o_fifo_read = fifo_read && !rstn;
  assign bus.o_valid     = valid_q;
  assign bus.o_px        = px_q;
  assign bus.o_py        = py_q;
  assign bus.o_full      = full_q;
  assign bus.o_last      = last_q;
  assign bus.o_busy      = busy_q;

endmodule
